pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It detects load-use hazards between the decode stage and the ID/EX register, and squashes wrong-path instructions on taken branches. It freezes the pipe while data memory is not ready and traps on invalid decodes or memory timeouts. It drives the write-enable, flush and bubble controls of PC, IF/ID and ID/EX, and the hold of the EX/MEM boundary.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_TRAP     = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_ILLEGAL     = 2'b01,
    CAUSE_MEM_TIMEOUT = 2'b10
  } trap_cause_e;

  // Number of FLUSH cycles spent after reset or trap acknowledge.
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  // Pipeline control bundle, ordered pc_write/ifid_write/ifid_flush/idex_bubble/ex_hold/trap.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic ex_hold;
    logic trap;
  } ctl_t;

  localparam ctl_t CTL_NORMAL = 6'b110000;
  localparam ctl_t CTL_HOLD   = 6'b000010;
  localparam ctl_t CTL_SQUASH = 6'b111100;
  localparam ctl_t CTL_BUBBLE = 6'b000100;
  localparam ctl_t CTL_TRAP   = 6'b000011;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and stall/flush control outputs.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_inv;
  logic       ex_memread;
  logic [4:0] ex_write_reg;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       trap_clear;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       ex_hold;
  logic       trap;
  logic [1:0] trap_cause;
  logic [1:0] state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_inv, ex_memread,
           ex_write_reg, ex_branch_taken, mem_req, mem_ready, trap_clear,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, trap,
           trap_cause, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_inv, ex_memread,
           ex_write_reg, ex_branch_taken, mem_req, mem_ready, trap_clear,
    output pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, trap,
           trap_cause, state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: the load in ID/EX writes a register
// that the instruction in ID is about to read. x0 never creates a hazard.
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_write_reg,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_write_reg);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_write_reg);
  assign load_use = ex_memread && (ex_write_reg != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall_cycles and
// flush_count performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_count
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  trap_cause_e       cause_q, cause_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  ctl_t              ctl;
  logic              load_use;
  logic              flush_taken;

  load_use_detect u_load_use_detect (
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .id_uses_rs1  (bus.id_uses_rs1),
    .id_uses_rs2  (bus.id_uses_rs2),
    .ex_memread   (bus.ex_memread),
    .ex_write_reg (bus.ex_write_reg),
    .load_use     (load_use)
  );

  // Next-state and zero-latency control outputs; RUN resolves hazards in priority order.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ctl         = CTL_HOLD;
    flush_taken = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          ctl        = CTL_HOLD;
          wait_cnt_d = WAIT_W'(1);
          state_d    = ST_MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
          ctl         = CTL_SQUASH;
          flush_taken = 1'b1;
        end else if (load_use) begin
          ctl = CTL_BUBBLE;
        end else if (bus.id_inv) begin
          ctl     = CTL_BUBBLE;
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end else begin
          ctl = CTL_NORMAL;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          ctl     = CTL_NORMAL;
          state_d = ST_RUN;
        end else begin
          ctl = CTL_HOLD;
          if (wait_cnt_q == WAIT_LAST) begin
            cause_d = CAUSE_MEM_TIMEOUT;
            state_d = ST_TRAP;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        ctl         = CTL_SQUASH;
        drain_cnt_d = drain_cnt_q - 2'd1;
        if (drain_cnt_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_TRAP: begin
        ctl = CTL_TRAP;
        if (bus.trap_clear) begin
          state_d     = ST_FLUSH;
          drain_cnt_d = DRAIN_CYCLES;
          cause_d     = CAUSE_NONE;
        end
      end
      default: begin
        ctl     = CTL_TRAP;
        state_d = ST_FLUSH;
      end
    endcase
  end

  // State, cause and counter registers; reset drops straight into a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      cause_q     <= CAUSE_NONE;
      drain_cnt_q <= DRAIN_CYCLES;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.pc_write    = ctl.pc_write;
  assign bus.ifid_write  = ctl.ifid_write;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_bubble = ctl.idex_bubble;
  assign bus.ex_hold     = ctl.ex_hold;
  assign bus.trap        = ctl.trap;
  assign bus.trap_cause  = cause_q;
  assign bus.state       = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Saturating counters: stalled RUN/MEM_WAIT cycles and taken-branch squashes.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !ctl.pc_write &&
        (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (flush_taken && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  logic unused_flush_taken;
  assign unused_flush_taken = flush_taken;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for single-cycle
// RUN-state hazard decisions plus hand sequences for multi-cycle behaviour.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  localparam logic [5:0] E_NORMAL = 6'b110000;
  localparam logic [5:0] E_HOLD   = 6'b000010;
  localparam logic [5:0] E_SQUASH = 6'b111100;
  localparam logic [5:0] E_BUBBLE = 6'b000100;
  localparam logic [5:0] E_TRAP   = 6'b000011;

  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_FL   = 2'b10;
  localparam logic [1:0] S_TRAP = 2'b11;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses1;
    logic       uses2;
    logic       inv;
    logic       memread;
    logic [4:0] wr;
    logic       br;
    logic       req;
    logic       rdy;
    logic       clr;
    logic [5:0] exp_ctl;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [5:0] act_ctl;

  pipeline_hazard_ctrl_if bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
`endif

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  assign act_ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                    bus.idex_bubble, bus.ex_hold, bus.trap};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic [5:0] ctl, input logic [1:0] st,
                          input logic [1:0] cause);
    checkOutput({name, "_ctl"}, 32'(act_ctl), 32'(ctl));
    checkOutput({name, "_state"}, 32'(bus.state), 32'(st));
    checkOutput({name, "_cause"}, 32'(bus.trap_cause), 32'(cause));
  endtask

  task automatic idleInputs();
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.id_inv          = 1'b0;
    bus.ex_memread      = 1'b0;
    bus.ex_write_reg    = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
    bus.trap_clear      = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.id_rs1          = v.rs1;
    bus.id_rs2          = v.rs2;
    bus.id_uses_rs1     = v.uses1;
    bus.id_uses_rs2     = v.uses2;
    bus.id_inv          = v.inv;
    bus.ex_memread      = v.memread;
    bus.ex_write_reg    = v.wr;
    bus.ex_branch_taken = v.br;
    bus.mem_req         = v.req;
    bus.mem_ready       = v.rdy;
    bus.trap_clear      = v.clr;
    #2;
  endtask

  task automatic nextIdle();
    @(negedge clk);
    idleInputs();
    #2;
  endtask

  vec_t vecs[10];

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{rs1:5'd0, rs2:5'd0, uses1:1'b0, uses2:1'b0, inv:1'b0, memread:1'b0, wr:5'd0,
                br:1'b0, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_NORMAL};
    vecs[1] = '{rs1:5'd5, rs2:5'd0, uses1:1'b1, uses2:1'b0, inv:1'b0, memread:1'b1, wr:5'd5,
                br:1'b0, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_BUBBLE};
    vecs[2] = '{rs1:5'd0, rs2:5'd0, uses1:1'b1, uses2:1'b0, inv:1'b0, memread:1'b1, wr:5'd0,
                br:1'b0, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_NORMAL};
    vecs[3] = '{rs1:5'd3, rs2:5'd7, uses1:1'b1, uses2:1'b1, inv:1'b0, memread:1'b1, wr:5'd7,
                br:1'b0, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_BUBBLE};
    vecs[4] = '{rs1:5'd3, rs2:5'd7, uses1:1'b1, uses2:1'b0, inv:1'b0, memread:1'b1, wr:5'd7,
                br:1'b0, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_NORMAL};
    vecs[5] = '{rs1:5'd9, rs2:5'd0, uses1:1'b1, uses2:1'b0, inv:1'b0, memread:1'b0, wr:5'd9,
                br:1'b0, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_NORMAL};
    vecs[6] = '{rs1:5'd0, rs2:5'd0, uses1:1'b0, uses2:1'b0, inv:1'b1, memread:1'b0, wr:5'd0,
                br:1'b1, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_SQUASH};
    vecs[7] = '{rs1:5'd5, rs2:5'd0, uses1:1'b1, uses2:1'b0, inv:1'b0, memread:1'b1, wr:5'd5,
                br:1'b1, req:1'b0, rdy:1'b0, clr:1'b0, exp_ctl:E_SQUASH};
    vecs[8] = '{rs1:5'd0, rs2:5'd0, uses1:1'b0, uses2:1'b0, inv:1'b0, memread:1'b0, wr:5'd0,
                br:1'b0, req:1'b1, rdy:1'b1, clr:1'b0, exp_ctl:E_NORMAL};
    vecs[9] = '{rs1:5'd0, rs2:5'd0, uses1:1'b0, uses2:1'b0, inv:1'b0, memread:1'b0, wr:5'd0,
                br:1'b0, req:1'b0, rdy:1'b0, clr:1'b1, exp_ctl:E_NORMAL};

    idleInputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkAll("reset", E_SQUASH, S_FL, 2'b00);

    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checkAll("rel_fl1", E_SQUASH, S_FL, 2'b00);
    nextIdle();
    checkAll("rel_fl2", E_SQUASH, S_FL, 2'b00);
    nextIdle();
    checkAll("rel_run", E_NORMAL, S_RUN, 2'b00);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_ctl", i), 32'(act_ctl), 32'(vecs[i].exp_ctl));
      checkOutput($sformatf("vec%0d_state", i), 32'(bus.state), 32'(S_RUN));
    end
    nextIdle();
    checkAll("table_end", E_NORMAL, S_RUN, 2'b00);

    applyStimulus(vecs[1]);
    checkAll("lu_stall", E_BUBBLE, S_RUN, 2'b00);
    @(negedge clk);
    bus.ex_memread = 1'b0;
    #2;
    checkAll("lu_release", E_NORMAL, S_RUN, 2'b00);

    @(negedge clk);
    idleInputs();
    bus.mem_req = 1'b1;
    #2;
    checkAll("mw_c0", E_HOLD, S_RUN, 2'b00);
    @(negedge clk); #2;
    checkAll("mw_c1", E_HOLD, S_WAIT, 2'b00);
    @(negedge clk); #2;
    checkAll("mw_c2", E_HOLD, S_WAIT, 2'b00);
    @(negedge clk);
    bus.mem_ready       = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #2;
    checkAll("mw_ready", E_NORMAL, S_WAIT, 2'b00);
    nextIdle();
    checkAll("mw_back", E_NORMAL, S_RUN, 2'b00);

    @(negedge clk);
    bus.mem_req = 1'b1;
    #2;
    for (int c = 0; c < int'(MEM_TIMEOUT); c++) begin
      checkAll($sformatf("to_c%0d", c), E_HOLD, (c == 0) ? S_RUN : S_WAIT, 2'b00);
      @(negedge clk); #2;
    end
    checkAll("to_trap", E_TRAP, S_TRAP, 2'b10);
    @(negedge clk);
    bus.id_inv          = 1'b1;
    bus.ex_branch_taken = 1'b1;
    bus.mem_ready       = 1'b1;
    #2;
    checkAll("to_ignore", E_TRAP, S_TRAP, 2'b10);
    @(negedge clk);
    idleInputs();
    bus.trap_clear = 1'b1;
    #2;
    checkAll("to_clr", E_TRAP, S_TRAP, 2'b10);
    nextIdle();
    checkAll("to_fl1", E_SQUASH, S_FL, 2'b00);
    nextIdle();
    checkAll("to_fl2", E_SQUASH, S_FL, 2'b00);
    nextIdle();
    checkAll("to_run", E_NORMAL, S_RUN, 2'b00);

    @(negedge clk);
    bus.id_inv = 1'b1;
    #2;
    checkAll("ill_c0", E_BUBBLE, S_RUN, 2'b00);
    nextIdle();
    checkAll("ill_trap", E_TRAP, S_TRAP, 2'b01);
    @(negedge clk);
    bus.trap_clear = 1'b1;
    #2;
    checkAll("ill_clr", E_TRAP, S_TRAP, 2'b01);
    nextIdle();
    checkAll("ill_fl1", E_SQUASH, S_FL, 2'b00);
    @(negedge clk);
    bus.trap_clear = 1'b1;
    #2;
    checkAll("ill_fl2_clr", E_SQUASH, S_FL, 2'b00);
    nextIdle();
    checkAll("ill_run", E_NORMAL, S_RUN, 2'b00);

    @(negedge clk);
    bus.mem_req = 1'b1;
    #2;
    checkAll("rst_c0", E_HOLD, S_RUN, 2'b00);
    @(negedge clk); #2;
    checkAll("rst_wait", E_HOLD, S_WAIT, 2'b00);
    #1 rst_n = 1'b0;
    #1;
    checkAll("rst_mid", E_SQUASH, S_FL, 2'b00);
`ifdef HAZ_PERF_CNT_EN
    checkOutput("rst_stall_cnt", stall_cycles, 32'd0);
    checkOutput("rst_flush_cnt", flush_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idleInputs();
    #2;
    checkAll("rst_fl1", E_SQUASH, S_FL, 2'b00);
    nextIdle();
    checkAll("rst_fl2", E_SQUASH, S_FL, 2'b00);
    nextIdle();
    checkAll("rst_run", E_NORMAL, S_RUN, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
